// File: rtl/moc_pkg.sv
// Shared types and constants for the multiple-output-circuit sweep controller.
package moc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } moc_state_e;

  localparam int NUM_VECTORS = 16;
  localparam int IN_W        = 4;
  localparam int RESP_W      = 3;

  // Bit offset of vector idx's 3-bit response inside the 48-bit packed table.
  function automatic logic [5:0] resp_slice(input logic [IN_W-1:0] idx);
    return 6'(idx) * 6'd3;
  endfunction

endpackage

// File: rtl/moc_settle_timer.sv
// 8-bit down-counter that times how long each vector is held before sampling.
module moc_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [7:0] i_load_val,
  output logic       o_expire
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_expire = (r_count == 8'd0);

endmodule

// File: rtl/moc_sweep_controller.sv
// Drives all 16 {A,B,C,D} vectors into the circuit, captures {Falpha,Fbeta,Fgamma}
// for each and scores the responses against EXP_TABLE.
module moc_sweep_controller
  import moc_pkg::*;
#(
  parameter int unsigned  SETTLE_CYCLES = 1,
  parameter logic [47:0]  EXP_TABLE     = 48'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        Falpha,
  input  logic        Fbeta,
  input  logic        Fgamma,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic        result_valid,
  output logic        pass,
  output logic [4:0]  fail_count,
  output logic [3:0]  first_fail_idx,
  output logic [47:0] response,
  output moc_state_e  dbg_state
);

  // Down-counter loaded with SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES APPLY cycles.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  moc_state_e        r_state;
  moc_state_e        w_next_state;
  logic [IN_W-1:0]   r_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_result_valid;
  logic              r_pass;
  logic [4:0]        r_fail_count;
  logic [3:0]        r_first_fail_idx;
  logic [47:0]       r_response;

  logic              w_expire;
  logic              w_load;
  logic              w_timer_en;
  logic              w_start_sweep;
  logic              w_abort;
  logic              w_capture;
  logic              w_advance;
  logic              w_finish;
  logic [RESP_W-1:0] w_resp_in;
  logic              w_mismatch;
  logic [4:0]        w_fail_next;

  moc_settle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_en       (w_timer_en),
    .i_load_val (SETTLE_LOAD),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = APPLY;
      APPLY:   if (abort) w_next_state = IDLE;
               else if (w_expire) w_next_state = SAMPLE;
      SAMPLE:  if (abort) w_next_state = IDLE;
               else if (r_idx == 4'(NUM_VECTORS - 1)) w_next_state = DONE;
               else w_next_state = APPLY;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_load        = 1'b0;
    w_timer_en    = 1'b0;
    w_start_sweep = 1'b0;
    w_abort       = 1'b0;
    w_capture     = 1'b0;
    w_load        = (w_next_state == APPLY) && (r_state != APPLY);
    w_timer_en    = (r_state == APPLY);
    w_start_sweep = (r_state == IDLE) && start;
    w_abort       = ((r_state == APPLY) || (r_state == SAMPLE)) && abort;
    w_capture     = (r_state == SAMPLE) && !abort;
  end

  assign w_advance   = w_capture && (r_idx != 4'(NUM_VECTORS - 1));
  assign w_finish    = w_capture && (r_idx == 4'(NUM_VECTORS - 1));
  assign w_resp_in   = {Falpha, Fbeta, Fgamma};
  assign w_mismatch  = (w_resp_in != EXP_TABLE[resp_slice(r_idx) +: RESP_W]);
  assign w_fail_next = (w_mismatch && (r_fail_count != 5'd16)) ? r_fail_count + 5'd1
                                                                : r_fail_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx            <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_result_valid   <= 1'b0;
      r_pass           <= 1'b0;
      r_fail_count     <= 5'd0;
      r_first_fail_idx <= 4'd0;
      r_response       <= 48'd0;
    end else begin
      r_done <= w_finish;
      if (w_start_sweep) begin
        r_idx            <= '0;
        r_busy           <= 1'b1;
        r_result_valid   <= 1'b0;
        r_pass           <= 1'b0;
        r_fail_count     <= 5'd0;
        r_first_fail_idx <= 4'd0;
        r_response       <= 48'd0;
      end else if (w_abort) begin
        r_idx  <= '0;
        r_busy <= 1'b0;
      end else if (w_capture) begin
        r_response[resp_slice(r_idx) +: RESP_W] <= w_resp_in;
        r_fail_count <= w_fail_next;
        if (w_mismatch && (r_fail_count == 5'd0)) r_first_fail_idx <= r_idx;
        if (w_advance) r_idx <= r_idx + 4'd1;
        // Results become visible together with the done pulse.
        if (w_finish) begin
          r_busy         <= 1'b0;
          r_result_valid <= 1'b1;
          r_pass         <= (w_fail_next == 5'd0);
        end
      end
    end
  end

  assign {A, B, C, D}   = r_idx;
  assign busy           = r_busy;
  assign done           = r_done;
  assign result_valid   = r_result_valid;
  assign pass           = r_pass;
  assign fail_count     = r_fail_count;
  assign first_fail_idx = r_first_fail_idx;
  assign response       = r_response;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_moc_sweep_controller.sv
// Bench for moc_sweep_controller: four instances with different settle times and
// expected tables, each looped back through a stub returning {A,B,C}.
module tb_moc_sweep_controller;
  import moc_pkg::*;

  function automatic logic [47:0] golden_table();
    logic [47:0] t;
    logic [3:0]  v;
    t = '0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      t[3*i +: 3] = v[3:1];
    end
    return t;
  endfunction

  localparam logic [47:0]  GOLD     = golden_table();
  localparam logic [47:0]  FAULT    = GOLD & ~(48'h7 << 15);
  localparam logic [47:0]  INV      = ~GOLD;
  localparam logic [31:0]  SETTLE_P = {8'd4, 8'd1, 8'd1, 8'd1};
  localparam logic [191:0] EXP_P    = {GOLD, INV, FAULT, GOLD};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        start_r;
  logic [3:0]        abort_r;
  logic [3:0]        a_w, b_w, c_w, d_w;
  logic [3:0]        busy_w, done_w, rv_w, pass_w;
  logic [3:0][4:0]   fc_w;
  logic [3:0][3:0]   ff_w;
  logic [3:0][47:0]  resp_w;
  moc_state_e        st_w [4];

  int total = 0;
  int bad   = 0;

  logic [57:0] res_q [$];
  logic [3:0]  vec_q [$];

  typedef struct {
    int         sel;
    int         settle;
    int         repulse;
    logic       pass;
    logic [4:0] fc;
    logic [3:0] ff;
  } sweep_vec_t;

  sweep_vec_t tbl [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    moc_sweep_controller #(
      .SETTLE_CYCLES (int'(SETTLE_P[g*8 +: 8])),
      .EXP_TABLE     (EXP_P[g*48 +: 48])
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start_r[g]),
      .abort          (abort_r[g]),
      .Falpha         (a_w[g]),
      .Fbeta          (b_w[g]),
      .Fgamma         (c_w[g]),
      .A              (a_w[g]),
      .B              (b_w[g]),
      .C              (c_w[g]),
      .D              (d_w[g]),
      .busy           (busy_w[g]),
      .done           (done_w[g]),
      .result_valid   (rv_w[g]),
      .pass           (pass_w[g]),
      .fail_count     (fc_w[g]),
      .first_fail_idx (ff_w[g]),
      .response       (resp_w[g]),
      .dbg_state      (st_w[g])
    );
  end

  function automatic logic [3:0] vec_of(input int s);
    return {a_w[s], b_w[s], c_w[s], d_w[s]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input int s, input string tag);
    check({tag, "_vec"},    64'(vec_of(s)), 64'd0);
    check({tag, "_busy"},   64'(busy_w[s]), 64'd0);
    check({tag, "_done"},   64'(done_w[s]), 64'd0);
    check({tag, "_rv"},     64'(rv_w[s]), 64'd0);
    check({tag, "_pass"},   64'(pass_w[s]), 64'd0);
    check({tag, "_fc"},     64'(fc_w[s]), 64'd0);
    check({tag, "_ff"},     64'(ff_w[s]), 64'd0);
    check({tag, "_resp"},   64'(resp_w[s]), 64'd0);
    check({tag, "_state"},  64'(st_w[s]), 64'(IDLE));
  endtask

  // Start a sweep, follow it cycle by cycle, and score the final result.
  task automatic run_sweep(input int sel, input int settle, input int repulse,
                           input logic [57:0] exp_res);
    int          per;
    logic [3:0]  cur;
    logic [57:0] want;
    per = settle + 1;
    res_q.push_back(exp_res);
    for (int i = 0; i < 16; i++) vec_q.push_back(4'(i));
    cur = 4'd0;
    @(negedge clk);
    start_r[sel] = 1'b1;
    @(posedge clk);
    #1 start_r[sel] = 1'b0;
    for (int c = 0; c <= 16 * per; c++) begin
      @(negedge clk);
      if (repulse >= 0) start_r[sel] = (c == repulse);
      if (c < 16 * per) begin
        if ((c % per) == 0 && vec_q.size() != 0) cur = vec_q.pop_front();
        check("busy_during", 64'(busy_w[sel]), 64'd1);
        check("vector", 64'(vec_of(sel)), 64'(cur));
        check("done_early", 64'(done_w[sel]), 64'd0);
      end else begin
        check("done_pulse", 64'(done_w[sel]), 64'd1);
        check("busy_end", 64'(busy_w[sel]), 64'd0);
        check("result_valid", 64'(rv_w[sel]), 64'd1);
        if (res_q.size() != 0) begin
          want = res_q.pop_front();
          check("result", 64'({pass_w[sel], fc_w[sel], ff_w[sel], resp_w[sel]}), 64'(want));
        end
      end
    end
    start_r[sel] = 1'b0;
    check("vec_q_drained", 64'(vec_q.size()), 64'd0);
  endtask

  initial begin
    tbl[0] = '{sel: 0, settle: 1, repulse: -1, pass: 1'b1, fc: 5'd0,  ff: 4'd0};
    tbl[1] = '{sel: 1, settle: 1, repulse: -1, pass: 1'b0, fc: 5'd1,  ff: 4'd5};
    tbl[2] = '{sel: 2, settle: 1, repulse: -1, pass: 1'b0, fc: 5'd16, ff: 4'd0};
    tbl[3] = '{sel: 3, settle: 4, repulse: 10, pass: 1'b1, fc: 5'd0,  ff: 4'd0};

    rst_n   = 1'b0;
    start_r = '0;
    abort_r = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) check_all_zero(s, "reset");
    rst_n = 1'b1;

    for (int t = 0; t < 4; t++)
      run_sweep(tbl[t].sel, tbl[t].settle, tbl[t].repulse,
                {tbl[t].pass, tbl[t].fc, tbl[t].ff, GOLD});

    // Start held through the DONE cycle is ignored there and accepted one cycle later.
    run_sweep(0, 1, -1, {1'b1, 5'd0, 4'd0, GOLD});
    start_r[0] = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", 64'(busy_w[0]), 64'd0);
    check("rv_after_done", 64'(rv_w[0]), 64'd1);
    @(negedge clk);
    start_r[0] = 1'b0;
    check("start_after_done_taken", 64'(busy_w[0]), 64'd1);
    check("rv_cleared_on_start", 64'(rv_w[0]), 64'd0);

    // Abort at cycle 7 of the sweep.
    repeat (7) @(negedge clk);
    abort_r[0] = 1'b1;
    @(negedge clk);
    abort_r[0] = 1'b0;
    check("abort_busy", 64'(busy_w[0]), 64'd0);
    check("abort_vec", 64'(vec_of(0)), 64'd0);
    check("abort_rv", 64'(rv_w[0]), 64'd0);
    check("abort_state", 64'(st_w[0]), 64'(IDLE));
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", 64'(done_w[0]), 64'd0);
      @(negedge clk);
    end
    run_sweep(0, 1, -1, {1'b1, 5'd0, 4'd0, GOLD});

    // Start and abort together in IDLE: start wins.
    @(negedge clk);
    start_r[0] = 1'b1;
    abort_r[0] = 1'b1;
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    abort_r[0] = 1'b0;
    @(negedge clk);
    check("start_beats_abort", 64'(busy_w[0]), 64'd1);

    // Asynchronous reset while vector 9 is applied.
    repeat (18) @(negedge clk);
    check("at_vector_9", 64'(vec_of(0)), 64'd9);
    check("busy_before_reset", 64'(busy_w[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero(0, "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(0, 1, -1, {1'b1, 5'd0, 4'd0, GOLD});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
